// File: rtl/switch_cfg_loader_pkg.sv
// Shared types for the switch configuration loader: flit layout, config entry
// record, payload field positions and the loader state encoding.
package switch_cfg_loader_pkg;

    localparam int CFG_NODE_W = 5;
    localparam int CFG_ADDR_W = 7;
    localparam int CFG_DATA_W = 16;

    localparam logic [3:0] FMT_SWITCH_CFG = 4'h1;

    // Payload bit positions, also used by the switch register bank decoder
    localparam int FMT_MSB  = 31;
    localparam int FMT_LSB  = 28;
    localparam int DEST_MSB = 27;
    localparam int DEST_LSB = 23;
    localparam int ADDR_MSB = 22;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    typedef struct packed {
        logic [3:0] src;
        logic [3:0] dest;
        logic [1:0] vc;
        logic       last;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t  metadata;
        logic [31:0] payload;
    } flit_t;

    typedef struct packed {
        logic [CFG_NODE_W-1:0] node;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } ldr_state_t;

    function automatic flit_t buildCfgFlit(input cfg_entry_t entry);
        flit_t f;
        f = '0;
        f.payload[FMT_MSB:FMT_LSB]   = FMT_SWITCH_CFG;
        f.payload[DEST_MSB:DEST_LSB] = entry.node;
        f.payload[ADDR_MSB:ADDR_LSB] = entry.addr;
        f.payload[DATA_MSB:DATA_LSB] = entry.data;
        f.metadata.vc                = 2'd0;
        return f;
    endfunction

endpackage

// File: rtl/switch_cfg_loader_fifo.sv
// Synchronous FIFO of config entries with occupancy count and a flush that
// empties it in one cycle.
module cfg_entry_fifo
    import switch_cfg_loader_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  cfg_entry_t               entry_i,
    input  logic                     pop_i,
    output cfg_entry_t               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cfg_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/switch_cfg_loader.sv
// Boot-time sequencer: queues host config writes and streams them as
// switch-config flits on VC0 under credit flow control, then waits for drain.
module switch_cfg_loader
    import switch_cfg_loader_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int BUFFER_SIZE = 8,
    parameter int NODE_W      = CFG_NODE_W,
    parameter int ADDR_W      = CFG_ADDR_W,
    parameter int DATA_W      = CFG_DATA_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [NODE_W-1:0]             cfg_node,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [DATA_W-1:0]             cfg_data,
    input  logic                          start,
    output flit_t                         flit_out,
    output logic                          data_ready_out,
    input  logic                          credit_granted,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRW = $clog2(BUFFER_SIZE) + 1;
    localparam int TOW = $clog2(TIMEOUT + 1);

    ldr_state_t      state_q;
    logic [CRW-1:0]  credits_q;
    logic [CRW-1:0]  credits_d;
    logic [TOW-1:0]  timeout_q;
    flit_t           flit_q;
    logic            dro_q;
    logic            done_q;
    logic            err_q;

    cfg_entry_t      push_entry;
    cfg_entry_t      fifo_head;
    logic [PW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    logic            push_now;
    logic            send_now;
    logic            last_pop;
    logic            timed_out;
    logic            credit_overflow;

    assign push_entry = '{node: cfg_node, addr: cfg_addr, data: cfg_data};
    assign cfg_ready  = !fifo_full;
    assign push_now   = cfg_valid && cfg_ready;
    assign send_now   = (state_q == SEND) && (credits_q != '0) && !fifo_empty;
    assign last_pop   = send_now && (fifo_count == PW'(1)) && !push_now;

    // Abort after TIMEOUT consecutive cycles with neither a send nor a returned credit
    assign timed_out  = (state_q != IDLE) && !send_now && !credit_granted
                        && (timeout_q == TOW'(TIMEOUT - 1));

    assign credit_overflow = credit_granted && !send_now && (credits_q == CRW'(BUFFER_SIZE));

    always_comb begin
        credits_d = credits_q;
        if (send_now && !credit_granted) begin
            credits_d = credits_q - CRW'(1);
        end else if (credit_granted && !send_now && !credit_overflow) begin
            credits_d = credits_q + CRW'(1);
        end
    end

    cfg_entry_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (timed_out),
        .push_i  (push_now),
        .entry_i (push_entry),
        .pop_i   (send_now),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            credits_q <= CRW'(BUFFER_SIZE);
            timeout_q <= '0;
            flit_q    <= '0;
            dro_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            dro_q     <= send_now;
            done_q    <= 1'b0;
            credits_q <= timed_out ? CRW'(BUFFER_SIZE) : credits_d;
            if (send_now) begin
                flit_q <= buildCfgFlit(fifo_head);
            end
            if (state_q == IDLE || send_now || credit_granted || timed_out) begin
                timeout_q <= '0;
            end else begin
                timeout_q <= timeout_q + TOW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (fifo_count != '0) state_q <= SEND;
                        else                  done_q  <= 1'b1;
                    end
                end
                SEND: begin
                    if (timed_out)     state_q <= IDLE;
                    else if (last_pop) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (timed_out) begin
                        state_q <= IDLE;
                    end else if (credits_d == CRW'(BUFFER_SIZE)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (timed_out || credit_overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign flit_out       = flit_q;
    assign data_ready_out = dro_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
    assign pending        = fifo_count;

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Directed self-checking bench for switch_cfg_loader with default parameters.
module tb_switch_cfg_loader;
    import switch_cfg_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [4:0]  cfg_node = '0;
    logic [6:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        start = 1'b0;
    flit_t       flit_out;
    logic        data_ready_out;
    logic        credit_granted = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  pending;

    int checkCount = 0;
    int passCount  = 0;

    switch_cfg_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_node       (cfg_node),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .start          (start),
        .flit_out       (flit_out),
        .data_ready_out (data_ready_out),
        .credit_granted (credit_granted),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushEntry(input logic [4:0] node, input logic [6:0] addr, input logic [15:0] data);
        cfg_valid = 1'b1;
        cfg_node  = node;
        cfg_addr  = addr;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    // Pattern entry i: node i+1, addr 0x10+i, data 0xA000+i
    task automatic setPattern(input int i);
        cfg_node = 5'(i + 1);
        cfg_addr = 7'(8'h10 + i);
        cfg_data = 16'hA000 + 16'(i);
    endtask

    function automatic logic [63:0] patternFlit(input int i);
        logic [4:0]  n;
        logic [6:0]  a;
        logic [15:0] d;
        n = 5'(i + 1);
        a = 7'(8'h10 + i);
        d = 16'hA000 + 16'(i);
        return {32'h0, 4'h1, n, a, d};
    endfunction

    task automatic applyStimulus(input int count);
        for (int i = 0; i < count; i++) begin
            setPattern(i);
            cfg_valid = 1'b1;
            step();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic returnCredits(input int count);
        credit_granted = 1'b1;
        for (int i = 0; i < count; i++) step();
        credit_granted = 1'b0;
    endtask

    // Queue 8 entries, start, expect 8 back-to-back flits, then full drain and done
    task automatic burst8(input string tag);
        applyStimulus(8);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput({tag, "_dro"}, 64'(data_ready_out), 64'd1);
            checkOutput({tag, "_flit"}, 64'(flit_out), patternFlit(i));
        end
        step();
        checkOutput({tag, "_idleDro"}, 64'(data_ready_out), 64'd0);
        returnCredits(8);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        step();
    endtask

    initial begin
        int  flitCount;
        logic doneSeen;

        step();
        step();
        checkOutput("rstReady", 64'(cfg_ready), 64'd1);
        checkOutput("rstPending", 64'(pending), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstErr", 64'(err), 64'd0);
        checkOutput("rstDro", 64'(data_ready_out), 64'd0);
        checkOutput("rstFlit", 64'(flit_out), 64'd0);
        rst = 1'b0;
        step();

        // Three hand-built entries
        pushEntry(5'd1, 7'h02, 16'h0001);
        pushEntry(5'd2, 7'h03, 16'h00AA);
        pushEntry(5'd0, 7'h7F, 16'hFFFF);
        checkOutput("pending3", 64'(pending), 64'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        checkOutput("noFlitYet", 64'(data_ready_out), 64'd0);
        step();
        checkOutput("t1Dro0", 64'(data_ready_out), 64'd1);
        checkOutput("t1Flit0", 64'(flit_out), 64'h1082_0001);
        step();
        checkOutput("t1Dro1", 64'(data_ready_out), 64'd1);
        checkOutput("t1Flit1", 64'(flit_out), 64'h1103_00AA);
        step();
        checkOutput("t1Dro2", 64'(data_ready_out), 64'd1);
        checkOutput("t1Flit2", 64'(flit_out), 64'h107F_FFFF);
        step();
        checkOutput("t1DroEnd", 64'(data_ready_out), 64'd0);
        checkOutput("t1FlitHold", 64'(flit_out), 64'h107F_FFFF);
        checkOutput("t1Draining", 64'(busy), 64'd1);
        credit_granted = 1'b1;
        step();
        step();
        checkOutput("t1EarlyDone", 64'(done), 64'd0);
        step();
        credit_granted = 1'b0;
        checkOutput("t1Done", 64'(done), 64'd1);
        checkOutput("t1Busy", 64'(busy), 64'd0);
        step();
        checkOutput("t1DonePulse", 64'(done), 64'd0);

        // Fill the queue, overflow attempt, then 10 entries against 8 credits
        applyStimulus(8);
        checkOutput("fullReady", 64'(cfg_ready), 64'd0);
        setPattern(20);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checkOutput("fullPending", 64'(pending), 64'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checkOutput("t2Flit0", 64'(flit_out), patternFlit(0));
        checkOutput("t2Pend7", 64'(pending), 64'd7);
        for (int i = 1; i < 8; i++) begin
            if (i == 1 || i == 2) begin
                setPattern(i + 7);
                cfg_valid = 1'b1;
            end
            step();
            cfg_valid = 1'b0;
            checkOutput("t2Dro", 64'(data_ready_out), 64'd1);
            checkOutput("t2Flit", 64'(flit_out), patternFlit(i));
            if (i <= 2) checkOutput("t2PushPopPend", 64'(pending), 64'd7);
        end
        checkOutput("t2Pend2", 64'(pending), 64'd2);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("t2Stall", 64'(data_ready_out), 64'd0);
        end
        checkOutput("t2StallPend", 64'(pending), 64'd2);
        credit_granted = 1'b1;
        step();
        credit_granted = 1'b0;
        checkOutput("t2GrantNoFlit", 64'(data_ready_out), 64'd0);
        step();
        checkOutput("t2Dro8", 64'(data_ready_out), 64'd1);
        checkOutput("t2Flit8", 64'(flit_out), patternFlit(8));
        step();
        checkOutput("t2Stall8", 64'(data_ready_out), 64'd0);
        returnCredits(1);
        step();
        checkOutput("t2Flit9", 64'(flit_out), patternFlit(9));
        checkOutput("t2Pend0", 64'(pending), 64'd0);
        returnCredits(7);
        checkOutput("t2NotDone", 64'(done), 64'd0);
        returnCredits(1);
        checkOutput("t2Done", 64'(done), 64'd1);
        step();

        // Start on an empty queue, then start while busy
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("emptyDone", 64'(done), 64'd1);
        checkOutput("emptyDro", 64'(data_ready_out), 64'd0);
        step();
        checkOutput("emptyDonePulse", 64'(done), 64'd0);
        applyStimulus(2);
        flitCount = 0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) start = 1'b0;
            if (data_ready_out) flitCount++;
            checkOutput("busyIgnoreDone", 64'(done), 64'd0);
        end
        checkOutput("busyFlitCount", 64'(flitCount), 64'd2);
        checkOutput("busyStillDrain", 64'(busy), 64'd1);
        returnCredits(2);
        checkOutput("busyDone", 64'(done), 64'd1);
        step();

        // Timeout with credits withheld in SEND
        applyStimulus(8);
        setPattern(30);
        cfg_valid = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        cfg_valid = 1'b0;
        checkOutput("toPendFull", 64'(pending), 64'd8);
        doneSeen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) doneSeen = 1'b1;
        end
        checkOutput("toErrEarly", 64'(err), 64'd0);
        for (int i = 0; i < 400 && !err; i++) begin
            step();
            if (done) doneSeen = 1'b1;
        end
        checkOutput("toErr", 64'(err), 64'd1);
        checkOutput("toFlushed", 64'(pending), 64'd0);
        checkOutput("toIdle", 64'(busy), 64'd0);
        checkOutput("toNoDone", 64'(doneSeen), 64'd0);
        step();
        checkOutput("toErrSticky", 64'(err), 64'd1);
        burst8("toRestored");
        checkOutput("startClearsErr", 64'(err), 64'd0);
        returnCredits(1);
        checkOutput("overflowErr", 64'(err), 64'd1);

        // Reset in the middle of a burst
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(8);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checkOutput("midDro", 64'(data_ready_out), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mrDro", 64'(data_ready_out), 64'd0);
        checkOutput("mrPending", 64'(pending), 64'd0);
        checkOutput("mrBusy", 64'(busy), 64'd0);
        checkOutput("mrErr", 64'(err), 64'd0);
        step();
        checkOutput("mrNoExtraFlit", 64'(data_ready_out), 64'd0);
        burst8("mrBurst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
